wb_dpbram_arbiter: RTL

- Two-master Wishbone (pipelined, single-word) arbiter and controller in front of the team's dual-port BRAM (write port A, registered read port B, 1-cycle read latency).
- Grants one master at a time with round-robin fairness and an optional hold limit.
- Steers writes to port A and reads to port B, and returns ack/data with a fixed 1-cycle latency.

---
 rtl/wb_dpbram_arbiter_pkg.sv | 13 +
 rtl/wb_rr_arbiter.sv | 79 +++++++
 rtl/wb_dpbram_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_dpbram_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone dual-port BRAM arbiter.
package wb_dpbram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  // Width of a master index (two masters).
  localparam int unsigned MIDX_W = 1;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin grant FSM for two Wishbone masters with an optional per-grant
// transfer quota that applies only while the other master is waiting.
module wb_rr_arbiter
  import wb_dpbram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_cyc0,
  input  logic i_cyc1,
  input  logic i_accept,
  output logic o_stall0,
  output logic o_stall1
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              other_cyc;
  logic              quota_hit;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    other_cyc = 1'b0;
    quota_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cyc0 && (!i_cyc1 || last_q)) state_d = ST_GRANT0;
        else if (i_cyc1)                    state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        other_cyc = i_cyc1;
        quota_hit = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && i_cyc1;
        if (!i_cyc0)        state_d = i_cyc1 ? ST_GRANT1 : ST_IDLE;
        else if (quota_hit) state_d = ST_GRANT1;
      end
      ST_GRANT1: begin
        other_cyc = i_cyc0;
        quota_hit = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && i_cyc0;
        if (!i_cyc1)        state_d = i_cyc0 ? ST_GRANT0 : ST_IDLE;
        else if (quota_hit) state_d = ST_GRANT0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_GRANT0 && state_q != ST_GRANT0) last_d = 1'b0;
    if (state_d == ST_GRANT1 && state_q != ST_GRANT1) last_d = 1'b1;

    if (state_d != state_q || !other_cyc)
      hold_d = '0;
    else if (i_accept && hold_q != HOLD_MAX)
      hold_d = hold_q + HOLD_W'(1);
  end

  // An exhausted quota stalls the owner for the switch cycle, so it gets
  // exactly MAX_HOLD transfers before the waiting master takes over.
  assign o_stall0 = i_reset || (state_q != ST_GRANT0) || quota_hit;
  assign o_stall1 = i_reset || (state_q != ST_GRANT1) || quota_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/wb_dpbram_arbiter.sv
// Two-master pipelined Wishbone front end for a dual-port BRAM: writes go to
// port A, reads to registered port B, with a fixed one-cycle ack/data return.
module wb_dpbram_arbiter
  import wb_dpbram_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wb0_cyc,
  input  logic                  i_wb0_stb,
  input  logic                  i_wb0_we,
  input  logic [ADDR_WIDTH-1:0] i_wb0_addr,
  input  logic [DATA_WIDTH-1:0] i_wb0_data,
  output logic                  o_wb0_stall,
  output logic                  o_wb0_ack,
  output logic [DATA_WIDTH-1:0] o_wb0_data,
  input  logic                  i_wb1_cyc,
  input  logic                  i_wb1_stb,
  input  logic                  i_wb1_we,
  input  logic [ADDR_WIDTH-1:0] i_wb1_addr,
  input  logic [DATA_WIDTH-1:0] i_wb1_data,
  output logic                  o_wb1_stall,
  output logic                  o_wb1_ack,
  output logic [DATA_WIDTH-1:0] o_wb1_data,
  output logic                  o_enA,
  output logic                  o_weA,
  output logic [ADDR_WIDTH-1:0] o_addrA,
  output logic [DATA_WIDTH-1:0] o_dinA,
  output logic                  o_enB,
  output logic [ADDR_WIDTH-1:0] o_addrB,
  input  logic [DATA_WIDTH-1:0] i_doutB
);

  logic                  accept0, accept1, accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic              ack_pend_q, ack_pend_d;
  logic [MIDX_W-1:0] ack_tag_q, ack_tag_d;
  logic              ack_we_q, ack_we_d;
  logic              ack_live;

  wb_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) u_arb (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_cyc0   (i_wb0_cyc),
    .i_cyc1   (i_wb1_cyc),
    .i_accept (accept),
    .o_stall0 (o_wb0_stall),
    .o_stall1 (o_wb1_stall)
  );

  assign accept0 = i_wb0_cyc && i_wb0_stb && !o_wb0_stall;
  assign accept1 = i_wb1_cyc && i_wb1_stb && !o_wb1_stall;
  assign accept  = accept0 || accept1;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (accept0) begin
      sel_we   = i_wb0_we;
      sel_addr = i_wb0_addr;
      sel_data = i_wb0_data;
    end else if (accept1) begin
      sel_we   = i_wb1_we;
      sel_addr = i_wb1_addr;
      sel_data = i_wb1_data;
    end

    o_enA   = 1'b0;
    o_weA   = 1'b0;
    o_addrA = '0;
    o_dinA  = '0;
    o_enB   = 1'b0;
    o_addrB = '0;
    if (accept && sel_we) begin
      o_enA   = 1'b1;
      o_weA   = 1'b1;
      o_addrA = sel_addr;
      o_dinA  = sel_data;
    end
    if (accept && !sel_we) begin
      o_enB   = 1'b1;
      o_addrB = sel_addr;
    end

    ack_pend_d = accept;
    ack_tag_d  = MIDX_W'(accept1);
    ack_we_d   = sel_we;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_pend_q <= 1'b0;
      ack_tag_q  <= '0;
      ack_we_q   <= 1'b0;
    end else begin
      ack_pend_q <= ack_pend_d;
      ack_tag_q  <= ack_tag_d;
      ack_we_q   <= ack_we_d;
    end
  end

  // Ack is qualified by the owner's live cyc (abort) and by reset, which
  // drops a pending ack in the same cycle it is asserted.
  assign ack_live   = ack_pend_q && !i_reset;
  assign o_wb0_ack  = ack_live && (ack_tag_q == MIDX_W'(0)) && i_wb0_cyc;
  assign o_wb1_ack  = ack_live && (ack_tag_q == MIDX_W'(1)) && i_wb1_cyc;
  assign o_wb0_data = (o_wb0_ack && !ack_we_q) ? i_doutB : '0;
  assign o_wb1_data = (o_wb1_ack && !ack_we_q) ? i_doutB : '0;

endmodule
